memory_cycle: RTL
=================

# memory_cycle

Memory pipeline stage that sits directly downstream of the execute stage. It consumes the M-stage bundle and performs the data-memory load or store over a valid/ready handshake, stalling the pipeline while the memory is not ready. It then registers the MEM/WB bundle for the writeback stage.

## Interface
- DATA_W, 32, datapath and memory word width
- REG_W, 6, destination register index width
- TIMEOUT_CYCLES, 16, unready cycles before abort; must be ≥2; used only with MEM_TIMEOUT_EN
- clk  in  1  clock; one clock domain
- rst  in  1  synchronous, active-high reset
- RegWriteM, MemWriteM, ResultSrcM  in  1 each  M-stage controls; ResultSrcM=1 marks a load
- RD_M  in  REG_W  destination register
- PCPlus4M, WriteDataM, ALU_ResultM  in  DATA_W each  M-stage data; ALU_ResultM is the byte address
- MemReqM  out  1  memory request
- MemWeM  out  1  store when 1
- MemAddrM, MemWDataM  out  DATA_W  address and store data
- MemReadyM  in  1  memory accepts or completes the request this cycle
- MemRDataM  in  DATA_W  load data, valid when MemReadyM=1
- StallM  out  1  upstream must hold the M bundle and stall the earlier stages
- RegWriteW, ResultSrcW  out  1 each
- RD_W  out  REG_W
- PCPlus4W, ALU_ResultW, ReadDataW  out  DATA_W each
- MemErrW  out  1  one-cycle abort flag

## Operation
- A memory access is present when MemWriteM | ResultSrcM.
- Request outputs are combinational from the M inputs:
  - MemReqM = access & ~rst & ~abort
  - MemWeM = MemWriteM
  - MemAddrM = ALU_ResultM
  - MemWDataM = WriteDataM
- Completion: a cycle with access & MemReadyM, or a cycle with no access at all.
- StallM = access & ~MemReadyM & ~abort & ~rst.
- FSM states, held in a register:
  - MEM_IDLE → MEM_WAIT on access & ~MemReadyM.
  - MEM_WAIT → MEM_IDLE on MemReadyM or abort.
  - MEM_WAIT otherwise holds.
- On each edge where StallM=0, the W registers capture the M bundle.
  - ReadDataW captures MemRDataM on a completed load.
  - ReadDataW holds its previous value otherwise.
- On each edge where StallM=1, the W registers capture a bubble: RegWriteW=0 and ResultSrcW=0. The remaining W data fields hold.
- Stores write no register. RegWriteW simply follows RegWriteM.

## Timing
- Zero-wait access: no stall. W outputs are valid one cycle after the M bundle.
- N-cycle memory (MemReadyM in the N-th cycle): StallM is high for N-1 cycles. MemReqM, MemAddrM and MemWDataM stay stable across all N cycles because upstream holds the bundle.
- wait_cnt:
  - Clears to 0 in MEM_IDLE.
  - Increments on each unready cycle.
  - Saturates; it never wraps.
- Back-to-back accesses are allowed. There are no idle cycles between completions.
- rst synchronous:
  - Next state is MEM_IDLE, wait_cnt=0.
  - All W outputs and MemErrW are 0.
  - MemReqM=0 and StallM=0 during every cycle with rst=1.
- rst mid-MEM_WAIT abandons the access. The memory must tolerate a dropped request.
- Reset values: RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW and MemErrW are all 0.

## Configuration
- MEM_TIMEOUT_EN defined:
  - abort = (state==MEM_WAIT) & (wait_cnt==TIMEOUT_CYCLES-1) & ~MemReadyM.
  - Abort fires in the TIMEOUT_CYCLES-th unready cycle. That cycle has StallM=0 and MemReqM=0.
  - On the following edge, W captures the bundle with RegWriteW forced to 0, and MemErrW=1 for exactly one cycle.
- MEM_TIMEOUT_EN undefined:
  - abort is tied to 0 and the stage waits indefinitely.
  - MemErrW is tied to 0.
  - wait_cnt is not instantiated.

## Structure
- Shared package memory_pkg holds:
  - enum mem_state_t {MEM_IDLE, MEM_WAIT}
  - DATA_W and REG_W defaults
  - the default TIMEOUT_CYCLES
- One sub-module, mem_wb_reg:
  - MEM/WB pipeline register with synchronous reset.
  - Inputs: a bubble input and the ReadData load-enable.
- FSM, counter and request logic live in memory_cycle.

## Test plan
- Zero-wait load: ResultSrcM=1, RegWriteM=1, ALU_ResultM=0x40, RD_M=5, MemReadyM=1, MemRDataM=0xDEADBEEF -> StallM=0; next cycle ReadDataW=0xDEADBEEF, RD_W=5, RegWriteW=1, ResultSrcW=1.
- Store with ready in the 3rd cycle: MemWriteM=1, ALU_ResultM=0x80, WriteDataM=0x1234 -> MemReqM=1 and MemWeM=1 for 3 cycles with addr/data stable; StallM=1 for 2 cycles; RegWriteW=0 throughout.
- ALU-only op: RegWriteM=1, ALU_ResultM=0x7, no access -> MemReqM=0, StallM=0; next cycle ALU_ResultW=0x7, RegWriteW=1.
- Timeout (MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4): load with MemReadyM held 0 -> StallM=1 for 3 cycles; 4th cycle StallM=0 and MemReqM=0; next cycle MemErrW=1 and RegWriteW=0; the cycle after, MemErrW=0. Without the macro: StallM stays 1 for 20 cycles.
- Reset mid-wait: rst=1 during MEM_WAIT -> MemReqM=0 and StallM=0 that cycle; after the edge, state is MEM_IDLE and all W outputs are 0.
- Load followed by an ALU op, both zero-wait -> two consecutive W updates with no bubble; the second gives ReadDataW unchanged and ResultSrcW=0.

Source files
------------

// File: rtl/memory_pkg.sv
// memory_pkg
// Shared definitions for the memory pipeline stage: the handshake FSM state
// encoding and the default widths and timeout used by memory_cycle and
// mem_wb_reg.
//
// Contents:
//   mem_state_t             - MEM_IDLE / MEM_WAIT handshake states
//   DATA_W_DEFAULT          - datapath and memory word width (32)
//   REG_W_DEFAULT           - destination register index width (6)
//   TIMEOUT_CYCLES_DEFAULT  - unready cycles before an access is aborted (16)

package memory_pkg;

    localparam int DATA_W_DEFAULT         = 32;
    localparam int REG_W_DEFAULT          = 6;
    localparam int TIMEOUT_CYCLES_DEFAULT = 16;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg
// MEM/WB pipeline register. On a normal edge it captures the M bundle; on a
// bubble edge it clears the two control bits (and the error flag) while the
// data fields hold their previous values. ReadData is only loaded when the
// stage completes a load, so it otherwise keeps the last loaded word.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   bubble              - insert a bubble instead of capturing the bundle
//   read_data_en        - load read_data_in into ReadData on this edge
//   reg_write_in, result_src_in, rd_in, pc_plus4_in, alu_result_in,
//   read_data_in, mem_err_in
//                       - next values for the W bundle
//   reg_write_w, result_src_w, rd_w, pc_plus4_w, alu_result_w,
//   read_data_w, mem_err_w
//                       - registered W bundle

import memory_pkg::*;

module mem_wb_reg #(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int REG_W  = REG_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bubble,
    input  logic              read_data_en,
    input  logic              reg_write_in,
    input  logic              result_src_in,
    input  logic [REG_W-1:0]  rd_in,
    input  logic [DATA_W-1:0] pc_plus4_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] read_data_in,
    input  logic              mem_err_in,
    output logic              reg_write_w,
    output logic              result_src_w,
    output logic [REG_W-1:0]  rd_w,
    output logic [DATA_W-1:0] pc_plus4_w,
    output logic [DATA_W-1:0] alu_result_w,
    output logic [DATA_W-1:0] read_data_w,
    output logic              mem_err_w
);

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_w  <= 1'b0;
            result_src_w <= 1'b0;
            rd_w         <= '0;
            pc_plus4_w   <= '0;
            alu_result_w <= '0;
            read_data_w  <= '0;
            mem_err_w    <= 1'b0;
        end else if (bubble) begin
            // A bubble must not write a register or look like a load to WB.
            reg_write_w  <= 1'b0;
            result_src_w <= 1'b0;
            mem_err_w    <= 1'b0;
        end else begin
            reg_write_w  <= reg_write_in;
            result_src_w <= result_src_in;
            rd_w         <= rd_in;
            pc_plus4_w   <= pc_plus4_in;
            alu_result_w <= alu_result_in;
            mem_err_w    <= mem_err_in;
            if (read_data_en) begin
                read_data_w <= read_data_in;
            end
        end
    end

endmodule

// File: rtl/memory_cycle.sv
// memory_cycle
// Memory pipeline stage following execute. Issues the data-memory load or
// store over a valid/ready handshake, stalls upstream while the memory is
// not ready, and registers the MEM/WB bundle.
//
// Optional feature: define MEM_TIMEOUT_EN to abort an access after
// TIMEOUT_CYCLES unready cycles (W captures the bundle with RegWriteW forced
// to 0 and MemErrW pulses for one cycle). Without it the stage waits
// indefinitely and MemErrW is constant 0.
//
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM,
//   ALU_ResultM                   - M-stage bundle (ResultSrcM=1 is a load)
//   MemReqM, MemWeM, MemAddrM, MemWDataM
//                                 - memory request (combinational)
//   MemReadyM, MemRDataM          - memory response
//   StallM                        - upstream must hold and stall
//   RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW, MemErrW
//                                 - registered W bundle

import memory_pkg::*;

module memory_cycle #(
    parameter int DATA_W         = DATA_W_DEFAULT,
    parameter int REG_W          = REG_W_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteM,
    input  logic              MemWriteM,
    input  logic              ResultSrcM,
    input  logic [REG_W-1:0]  RD_M,
    input  logic [DATA_W-1:0] PCPlus4M,
    input  logic [DATA_W-1:0] WriteDataM,
    input  logic [DATA_W-1:0] ALU_ResultM,
    output logic              MemReqM,
    output logic              MemWeM,
    output logic [DATA_W-1:0] MemAddrM,
    output logic [DATA_W-1:0] MemWDataM,
    input  logic              MemReadyM,
    input  logic [DATA_W-1:0] MemRDataM,
    output logic              StallM,
    output logic              RegWriteW,
    output logic              ResultSrcW,
    output logic [REG_W-1:0]  RD_W,
    output logic [DATA_W-1:0] PCPlus4W,
    output logic [DATA_W-1:0] ALU_ResultW,
    output logic [DATA_W-1:0] ReadDataW,
    output logic              MemErrW
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("memory_cycle: TIMEOUT_CYCLES must be at least 2");
    end

    mem_state_t state_q;
    mem_state_t state_d;
    logic       access;
    logic       abort;

    assign access = MemWriteM | ResultSrcM;

    assign MemReqM   = access & ~rst & ~abort;
    assign MemWeM    = MemWriteM;
    assign MemAddrM  = ALU_ResultM;
    assign MemWDataM = WriteDataM;
    assign StallM    = access & ~MemReadyM & ~abort & ~rst;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MEM_IDLE: if (access && !MemReadyM) state_d = MEM_WAIT;
            MEM_WAIT: if (MemReadyM || abort)   state_d = MEM_IDLE;
            default:  state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MEM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_d;

    // The first unready cycle happens in MEM_IDLE with the count at 0, so the
    // count equals TIMEOUT_CYCLES-1 during the TIMEOUT_CYCLES-th unready cycle.
    assign abort = (state_q == MEM_WAIT) &&
                   (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) && !MemReadyM;

    always_comb begin
        wait_cnt_d = wait_cnt;
        if (state_d == MEM_IDLE) begin
            wait_cnt_d = '0;
        end else if (access && !MemReadyM && (wait_cnt != '1)) begin
            wait_cnt_d = wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt_d;
        end
    end
`else
    assign abort = 1'b0;
`endif

    // An aborted load must not reach the register file; the data still
    // advances so WB sees a consistent (but non-writing) bundle.
    mem_wb_reg #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_mem_wb_reg (
        .clk           (clk),
        .rst           (rst),
        .bubble        (StallM),
        .read_data_en  (ResultSrcM & MemReadyM),
        .reg_write_in  (RegWriteM & ~abort),
        .result_src_in (ResultSrcM),
        .rd_in         (RD_M),
        .pc_plus4_in   (PCPlus4M),
        .alu_result_in (ALU_ResultM),
        .read_data_in  (MemRDataM),
        .mem_err_in    (abort),
        .reg_write_w   (RegWriteW),
        .result_src_w  (ResultSrcW),
        .rd_w          (RD_W),
        .pc_plus4_w    (PCPlus4W),
        .alu_result_w  (ALU_ResultW),
        .read_data_w   (ReadDataW),
        .mem_err_w     (MemErrW)
    );

endmodule
